// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: clear, arm, wait for hit, settle, capture.
// Results are queued in a small FIFO and streamed out over valid/ready.
module tdc_meas_ctrl #(
  parameter int DIG_W         = 24,
  parameter int SETTLE_CYCLES = 17,
  parameter int RST_CYCLES    = 2,
  parameter int TIMEOUT_W     = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int SEQ_W         = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           cont_mode,
  input  logic                           stop,
  input  logic [TIMEOUT_W-1:0]           timeout_val,
  input  logic                           hit_async,
  input  logic [DIG_W-1:0]               tdc_word,
  output logic                           tdc_rst,
  output logic                           armed,
  output logic                           busy,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DIG_W-1:0]               m_data,
  output logic [SEQ_W-1:0]               m_seq,
  output logic                           m_timeout,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [7:0]                     drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARMED,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t state_q, state_d;

  logic hs1_q, hs2_q, hs3_q;
  logic hit_edge;

  logic                 cont_q, cont_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [TIMEOUT_W-1:0] tmo_val_q, tmo_val_d;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]           rst_cnt_q, rst_cnt_d;
  logic [7:0]           settle_cnt_q, settle_cnt_d;
  logic                 cap_tmo_q, cap_tmo_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic                 push;
  logic                 tmo_hit;

  logic [DIG_W-1:0] dat_q [FIFO_DEPTH];
  logic [DIG_W-1:0] dat_d [FIFO_DEPTH];
  logic [SEQ_W-1:0] sq_q  [FIFO_DEPTH];
  logic [SEQ_W-1:0] sq_d  [FIFO_DEPTH];
  logic             tf_q  [FIFO_DEPTH];
  logic             tf_d  [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [7:0]       drop_q, drop_d;
  logic             pop, full, wr, drop;

  assign hit_edge = hs2_q & ~hs3_q;
  assign tmo_hit  = (tmo_val_q != '0) &&
                    (tmo_cnt_q == tmo_val_q - TIMEOUT_W'(1));

  always_comb begin
    state_d      = state_q;
    cont_d       = cont_q;
    stop_pend_d  = stop_pend_q;
    tmo_val_d    = tmo_val_q;
    tmo_cnt_d    = tmo_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    settle_cnt_d = settle_cnt_q;
    cap_tmo_d    = cap_tmo_q;
    seq_d        = seq_q;
    push         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          cont_d    = cont_mode;
          tmo_val_d = timeout_val;
          rst_cnt_d = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        tmo_cnt_d = '0;
        if (stop) begin
          cont_d      = 1'b0;
          stop_pend_d = 1'b1;
          rst_cnt_d   = '0;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d = stop_pend_q ? S_IDLE : S_ARMED;
        end else begin
          rst_cnt_d = rst_cnt_q + 4'd1;
        end
      end
      S_ARMED: begin
        if (stop) begin
          cont_d      = 1'b0;
          stop_pend_d = 1'b1;
          rst_cnt_d   = '0;
          state_d     = S_CLEAR;
        end else if (hit_edge) begin
          settle_cnt_d = '0;
          cap_tmo_d    = 1'b0;
          state_d      = S_SETTLE;
        end else if (tmo_hit) begin
          cap_tmo_d = 1'b1;
          state_d   = S_CAPTURE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
        end
      end
      S_SETTLE: begin
        if (stop) begin
          cont_d      = 1'b0;
          stop_pend_d = 1'b1;
          rst_cnt_d   = '0;
          state_d     = S_CLEAR;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      S_CAPTURE: begin
        push      = 1'b1;
        seq_d     = seq_q + SEQ_W'(1);
        rst_cnt_d = '0;
        if (stop) begin
          cont_d      = 1'b0;
          stop_pend_d = 1'b1;
          state_d     = S_CLEAR;
        end else begin
          state_d = cont_q ? S_CLEAR : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Full FIFO with a simultaneous pop still accepts the push.
  always_comb begin
    pop      = (level_q != '0) & m_ready;
    full     = (level_q == FULL_LVL);
    wr       = push & (~full | pop);
    drop     = push & full & ~pop;
    dat_d    = dat_q;
    sq_d     = sq_q;
    tf_d     = tf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    if (wr) begin
      dat_d[wr_ptr_q] = cap_tmo_q ? '0 : tdc_word;
      sq_d[wr_ptr_q]  = seq_q;
      tf_d[wr_ptr_q]  = cap_tmo_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr & ~pop) level_d = level_q + LW'(1);
    else if (~wr & pop) level_d = level_q - LW'(1);
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hs1_q        <= 1'b0;
      hs2_q        <= 1'b0;
      hs3_q        <= 1'b0;
      cont_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      tmo_val_q    <= '0;
      tmo_cnt_q    <= '0;
      rst_cnt_q    <= '0;
      settle_cnt_q <= '0;
      cap_tmo_q    <= 1'b0;
      seq_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      drop_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        dat_q[i] <= '0;
        sq_q[i]  <= '0;
        tf_q[i]  <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      hs1_q        <= hit_async;
      hs2_q        <= hs1_q;
      hs3_q        <= hs2_q;
      cont_q       <= cont_d;
      stop_pend_q  <= stop_pend_d;
      tmo_val_q    <= tmo_val_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      cap_tmo_q    <= cap_tmo_d;
      seq_q        <= seq_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      drop_q       <= drop_d;
      dat_q        <= dat_d;
      sq_q         <= sq_d;
      tf_q         <= tf_d;
    end
  end

  assign tdc_rst    = (state_q == S_CLEAR);
  assign armed      = (state_q == S_ARMED);
  assign busy       = (state_q != S_IDLE);
  assign m_valid    = (level_q != '0);
  assign m_data     = dat_q[rd_ptr_q];
  assign m_seq      = sq_q[rd_ptr_q];
  assign m_timeout  = tf_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl: single shot, timeout, continuous
// backpressure, full push/pop, stop in settle and async reset.
module tb_tdc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cont_mode = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] timeout_val = '0;
  logic        hit_async = 1'b0;
  logic [23:0] tdc_word = '0;
  logic        tdc_rst;
  logic        armed;
  logic        busy;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [23:0] m_data;
  logic [7:0]  m_seq;
  logic        m_timeout;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_seq [4] = '{8'd1, 8'd2, 8'd3, 8'd6};
  logic [23:0] exp_dat [4] = '{24'h100001, 24'h100002,
                               24'h100003, 24'h0ABCDE};

  tdc_meas_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cont_mode(cont_mode),
    .stop(stop), .timeout_val(timeout_val), .hit_async(hit_async),
    .tdc_word(tdc_word), .tdc_rst(tdc_rst), .armed(armed),
    .busy(busy), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_seq(m_seq), .m_timeout(m_timeout),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    hit_async = 1'b0;
    m_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic pulse_start(input logic c, input logic [15:0] t);
    cont_mode = c;
    timeout_val = t;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_armed(input string tag);
    int n = 0;
    while (!armed && n < 100) begin
      tick(1);
      n++;
    end
    checks++;
    if (!armed) begin
      errors++;
      $display("FAIL %s: armed never rose within 100 cycles", tag);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, armed, tdc_rst, m_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: busy/armed/tdc_rst/valid=%b need 0000",
               {busy, armed, tdc_rst, m_valid});
    end
    checks++;
    if (fifo_level !== 3'd0 || drop_cnt !== 8'd0 || m_data !== 24'd0) begin
      errors++;
      $display("FAIL reset_fifo: level=%0d drop=%0d data=%h need 0",
               fifo_level, drop_cnt, m_data);
    end
  endtask

  task automatic test_single();
    int n = 0;
    int g = 0;
    m_ready = 1'b1;
    pulse_start(1'b0, 16'd0);
    while (!armed && g < 20) begin
      if (tdc_rst) n++;
      tick(1);
      g++;
    end
    checks++;
    if (n != 2 || !armed) begin
      errors++;
      $display("FAIL single_rst: tdc_rst cycles=%0d armed=%b need 2/1",
               n, armed);
    end
    tick(10);
    tdc_word = 24'hA53C0F;
    hit_async = 1'b1;
    n = 0;
    while (!m_valid && n < 60) begin
      tick(1);
      n++;
    end
    hit_async = 1'b0;
    checks++;
    if (n != 21) begin
      errors++;
      $display("FAIL single_lat: hit to valid=%0d need 21", n);
    end
    checks++;
    if (m_data !== 24'hA53C0F || m_seq !== 8'd0 || m_timeout !== 1'b0) begin
      errors++;
      $display("FAIL single_data: data=%h seq=%0d tmo=%b need a53c0f/0/0",
               m_data, m_seq, m_timeout);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: busy=%b need 0", busy);
    end
    tick(1);
    checks++;
    if (m_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL single_pop: valid=%b level=%0d need 0/0",
               m_valid, fifo_level);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    m_ready = 1'b1;
    pulse_start(1'b0, 16'd100);
    wait_armed("timeout_arm");
    while (armed && n < 300) begin
      n++;
      tick(1);
    end
    checks++;
    if (n != 100 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_len: armed cycles=%0d valid=%b need 100/0",
               n, m_valid);
    end
    tick(1);
    checks++;
    if (m_valid !== 1'b1 || m_timeout !== 1'b1 || m_data !== 24'd0 ||
        m_seq !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rec: v=%b tmo=%b data=%h seq=%0d busy=%b",
               m_valid, m_timeout, m_data, m_seq, busy);
    end
    tick(1);
  endtask

  task automatic test_cont_backpressure();
    int g = 0;
    do_reset();
    m_ready = 1'b0;
    pulse_start(1'b1, 16'd0);
    for (int k = 0; k < 6; k++) begin
      wait_armed("cont_arm");
      tdc_word = 24'h100000 + 24'(k);
      hit_async = 1'b1;
      tick(3);
      hit_async = 1'b0;
    end
    wait_armed("cont_rearm");
    checks++;
    if (fifo_level !== 3'd4 || drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL cont_level: level=%0d drop=%0d need 4/2",
               fifo_level, drop_cnt);
    end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    while (busy && g < 20) begin
      tick(1);
      g++;
    end
    tick(3);
    checks++;
    if (busy !== 1'b0 || fifo_level !== 3'd4 || m_seq !== 8'd0 ||
        m_data !== 24'h100000) begin
      errors++;
      $display("FAIL cont_stop: busy=%b level=%0d seq=%0d data=%h",
               busy, fifo_level, m_seq, m_data);
    end
  endtask

  task automatic test_full_push_pop();
    tdc_word = 24'h0ABCDE;
    pulse_start(1'b0, 16'd0);
    wait_armed("full_arm");
    hit_async = 1'b1;
    tick(3);
    hit_async = 1'b0;
    tick(17);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    checks++;
    if (fifo_level !== 3'd4 || drop_cnt !== 8'd2 || m_seq !== 8'd1 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL full_pp: level=%0d drop=%0d seq=%0d busy=%b",
               fifo_level, drop_cnt, m_seq, busy);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_seq !== exp_seq[i] ||
          m_data !== exp_dat[i]) begin
        errors++;
        $display("FAIL drain_%0d: v=%b seq=%0d data=%h need seq=%0d data=%h",
                 i, m_valid, m_seq, m_data, exp_seq[i], exp_dat[i]);
      end
      tick(1);
    end
    checks++;
    if (m_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL drain_end: valid=%b level=%0d need 0/0",
               m_valid, fifo_level);
    end
  endtask

  task automatic test_stop_settle();
    int n = 0;
    int g = 0;
    m_ready = 1'b1;
    tdc_word = 24'h555555;
    pulse_start(1'b0, 16'd0);
    wait_armed("stop_arm");
    hit_async = 1'b1;
    tick(3);
    hit_async = 1'b0;
    tick(2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    while (busy && g < 50) begin
      if (tdc_rst) n++;
      tick(1);
      g++;
    end
    checks++;
    if (n != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_clear: tdc_rst cycles=%0d busy=%b need 2/0",
               n, busy);
    end
    tick(25);
    checks++;
    if (m_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL stop_nopush: valid=%b level=%0d need 0/0",
               m_valid, fifo_level);
    end
    hit_async = 1'b1;
    tick(4);
    hit_async = 1'b0;
    tick(30);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || tdc_rst !== 1'b0) begin
      errors++;
      $display("FAIL idle_hit: busy=%b valid=%b tdc_rst=%b need 000",
               busy, m_valid, tdc_rst);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    do_reset();
    m_ready = 1'b0;
    pulse_start(1'b1, 16'd0);
    for (int k = 0; k < 2; k++) begin
      wait_armed("ar_arm");
      hit_async = 1'b1;
      tick(3);
      hit_async = 1'b0;
    end
    wait_armed("ar_arm3");
    hit_async = 1'b1;
    tick(3);
    hit_async = 1'b0;
    tick(5);
    checks++;
    if (fifo_level !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre: level=%0d busy=%b need 2/1", fifo_level, busy);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({m_valid, busy, tdc_rst, armed} !== 4'b0000 ||
        fifo_level !== 3'd0 || m_seq !== 8'd0) begin
      errors++;
      $display("FAIL ar_now: v/b/r/a=%b level=%0d seq=%0d need 0",
               {m_valid, busy, tdc_rst, armed}, fifo_level, m_seq);
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    m_ready = 1'b1;
    tdc_word = 24'h123456;
    pulse_start(1'b0, 16'd0);
    wait_armed("ar_after");
    hit_async = 1'b1;
    tick(3);
    hit_async = 1'b0;
    while (!m_valid && n < 60) begin
      tick(1);
      n++;
    end
    checks++;
    if (m_valid !== 1'b1 || m_seq !== 8'd0 || m_data !== 24'h123456) begin
      errors++;
      $display("FAIL ar_seq: v=%b seq=%0d data=%h need 1/0/123456",
               m_valid, m_seq, m_data);
    end
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_cont_backpressure();
    test_full_push_pop();
    test_stop_settle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
Measurement sequencer for the TDC merging/readout path. It clears the TDC, arms it, and waits for the hit (fall) event. It then waits for the merged word to settle, captures it, and buffers results in a small FIFO with a valid/ready stream toward the host/UART side. It supports single-shot and continuous modes, hit timeout, and overflow accounting.

Parameters:
DIG_W, 24, width of merged TDC word (Coarse, StartEdge, FallEdge concatenation)
SETTLE_CYCLES, 17, clk cycles from synchronized hit edge to capture; must cover the merging counter span plus margin; legal range 1..255
RST_CYCLES, 2, length of tdc_rst pulse in CLEAR; legal range 1..15
TIMEOUT_W, 16, width of timeout_val
FIFO_DEPTH, 4, result FIFO entries; must be a power of 2 and at least 2
SEQ_W, 8, sequence tag width

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  one-cycle pulse; begins measurement when IDLE
cont_mode  in  1  sampled at start; 1 = re-arm automatically after each capture
stop  in  1  one-cycle pulse; aborts/ends continuous operation
timeout_val  in  TIMEOUT_W  ARMED timeout in cycles; 0 = disabled; sampled at start
hit_async  in  1  raw fall/hit signal, asynchronous to clk
tdc_word  in  DIG_W  merged TDC output word
tdc_rst  out  1  reset to TDC chain and merging logic
armed  out  1  high in ARMED state
busy  out  1  high whenever state != IDLE
m_valid  out  1  result available
m_ready  in  1  consumer accepts result
m_data  out  DIG_W  captured word (0 on timeout)
m_seq  out  SEQ_W  measurement sequence tag
m_timeout  out  1  entry is a timeout record
fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy
drop_cnt  out  8  saturating count of results lost to full FIFO

Behaviour:
Reset:
- rst is asynchronous, active-high; clock is clk (rising edge).
- On reset: state = IDLE; all outputs 0; FIFO empty; seq = 0; drop_cnt = 0; synchronizer flops = 0; cont latch = 0.

Hit synchronizer:
- 2-flop synchronizer plus one delay flop. hit_edge = s2 & ~s3.
- hit_edge occurs 2-3 cycles after the hit_async rise.

FSM:
- IDLE: a start pulse latches cont_mode and timeout_val, then goes to CLEAR. stop has no effect.
- CLEAR: tdc_rst = 1 for exactly RST_CYCLES cycles, then ARMED. The timeout counter loads 0.
- ARMED:
  - On hit_edge, go to SETTLE; the settle counter loads 0.
  - Otherwise, if timeout_val != 0 and the timeout counter reaches timeout_val - 1, go to CAPTURE with the timeout flag set.
  - If hit_edge and timeout occur in the same cycle, the hit wins.
- SETTLE: count SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE (1 cycle):
  - Push {tdc_word or 0, seq, timeout flag}.
  - seq increments by 1 on every capture, dropped or not, and wraps modulo 2^SEQ_W.
  - Next state is CLEAR if the cont latch = 1, else IDLE.
- Hit edges outside ARMED are ignored.
- start while busy is ignored.

stop:
- Clears the cont latch.
- In CLEAR, ARMED or SETTLE: go to CLEAR with the RST_CYCLES counter restarted, then IDLE. No push occurs.
- In CAPTURE: the push completes, then CLEAR and IDLE.

FIFO:
- Registered. Head entry drives m_data, m_seq and m_timeout.
- m_valid = (level != 0). A pushed entry into an empty FIFO appears on m_valid the cycle after CAPTURE.
- Pop occurs on m_valid & m_ready. m_data is stable while m_valid & !m_ready.
- Push and pop in the same cycle: both occur, level unchanged, including when full.
- Push when full without pop: entry discarded, drop_cnt += 1, saturating at 255.
- m_valid is independent of FSM state; the FIFO keeps draining after stop.

Latency:
- Single-shot end to end is RST_CYCLES + sync (2-3) + SETTLE_CYCLES + 1 (CAPTURE) + 1 cycles.

Test Plan:
- Single shot: start (cont=0, timeout=0), hit at 10 cycles after arming, tdc_word = 24'hA5_3C_0F, m_ready = 1 -> tdc_rst high for 2 cycles; one entry: m_data = A53C0F, m_seq = 0, m_timeout = 0; busy low after CAPTURE.
- Timeout: timeout_val = 100, no hit -> entry with m_data = 0, m_timeout = 1 exactly 100 cycles after armed rises; state returns to IDLE.
- Continuous with backpressure: cont = 1, m_ready = 0, 6 hits -> fifo_level = 4, drop_cnt = 2, seq values in FIFO 0..3; then m_ready = 1 -> 4 entries drain in order.
- Simultaneous push/pop when full: level stays 4, drop_cnt unchanged, and the next output is the correct sequence.
- stop in SETTLE: no entry is pushed, tdc_rst pulses for 2 cycles, then IDLE; a stray hit during IDLE is ignored.
- Async rst asserted mid-SETTLE with 2 entries queued -> immediately m_valid = 0, level = 0, seq = 0, tdc_rst = 0, state IDLE.
